// File: rtl/lsu_mem_if.sv
// Load/store unit: turns one execute-stage load/store into a word-indexed
// memory transaction and returns extended load data or an alignment fault.
module lsu_mem_if #(
  parameter int unsigned IDX_W = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             is_load,
  input  logic             is_store,
  input  logic [5:0]       alucode,
  input  logic [31:0]      addr,
  input  logic [31:0]      w_data,
  output logic             rsp_valid,
  output logic [31:0]      rsp_data,
  output logic             misaligned,
  output logic             mem_req,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [IDX_W-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata
);

  localparam logic [5:0] ALU_LB  = 6'd11;
  localparam logic [5:0] ALU_LH  = 6'd12;
  localparam logic [5:0] ALU_LW  = 6'd13;
  localparam logic [5:0] ALU_LBU = 6'd14;
  localparam logic [5:0] ALU_LHU = 6'd15;
  localparam logic [5:0] ALU_SB  = 6'd16;
  localparam logic [5:0] ALU_SH  = 6'd17;
  localparam logic [5:0] ALU_SW  = 6'd18;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_R, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [5:0]       r_op, w_op_nxt;
  logic [1:0]       r_lane, w_lane_nxt;
  logic             r_req_ready, w_req_ready_nxt;
  logic             r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]      r_rsp_data, w_rsp_data_nxt;
  logic             r_misaligned, w_misaligned_nxt;
  logic             r_mem_req, w_mem_req_nxt;
  logic             r_mem_we, w_mem_we_nxt;
  logic [3:0]       r_mem_be, w_mem_be_nxt;
  logic [IDX_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [31:0]      r_mem_wdata, w_mem_wdata_nxt;

  logic             w_st, w_ld, w_known, w_fault;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_ext;
  logic             w_unused;

  // Upper address bits beyond the word index are deliberately ignored.
  assign w_unused = ^addr[31:IDX_W+2];

  // Decode the incoming request: legality, alignment, byte enables, lane data.
  always_comb begin
    w_st    = is_store;
    w_ld    = is_load & ~is_store;
    w_known = 1'b0;
    w_fault = 1'b0;
    w_be    = 4'hF;
    w_wdata = 32'h0;
    case (alucode)
      ALU_LB, ALU_LBU: w_known = w_ld;
      ALU_LH, ALU_LHU: begin
        w_known = w_ld;
        w_fault = w_ld & addr[0];
      end
      ALU_LW: begin
        w_known = w_ld;
        w_fault = w_ld & (addr[1:0] != 2'b00);
      end
      ALU_SB: begin
        w_known = w_st;
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{w_data[7:0]}};
      end
      ALU_SH: begin
        w_known = w_st;
        w_fault = w_st & addr[0];
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{w_data[15:0]}};
      end
      ALU_SW: begin
        w_known = w_st;
        w_fault = w_st & (addr[1:0] != 2'b00);
        w_be    = 4'hF;
        w_wdata = w_data;
      end
      default: ;
    endcase
  end

  // Select the addressed lane of the read word and extend it.
  always_comb begin
    case (r_lane)
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_op)
      ALU_LB:  w_ext = {{24{w_byte[7]}}, w_byte};
      ALU_LBU: w_ext = {24'h0, w_byte};
      ALU_LH:  w_ext = {{16{w_half[15]}}, w_half};
      ALU_LHU: w_ext = {16'h0, w_half};
      ALU_LW:  w_ext = mem_rdata;
      default: w_ext = 32'h0;
    endcase
  end

  // Next state and next registered outputs; outputs default to zero.
  always_comb begin
    w_state_nxt      = r_state;
    w_op_nxt         = r_op;
    w_lane_nxt       = r_lane;
    w_req_ready_nxt  = 1'b0;
    w_rsp_valid_nxt  = 1'b0;
    w_rsp_data_nxt   = 32'h0;
    w_misaligned_nxt = 1'b0;
    w_mem_req_nxt    = 1'b0;
    w_mem_we_nxt     = 1'b0;
    w_mem_be_nxt     = 4'h0;
    w_mem_addr_nxt   = '0;
    w_mem_wdata_nxt  = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (req_valid && (is_load || is_store)) begin
          w_op_nxt   = alucode;
          w_lane_nxt = addr[1:0];
          if (w_known && !w_fault) begin
            w_state_nxt     = S_ISSUE;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = w_st;
            w_mem_be_nxt    = w_be;
            w_mem_addr_nxt  = addr[IDX_W+1:2];
            w_mem_wdata_nxt = w_wdata;
          end else begin
            w_state_nxt      = S_DONE;
            w_rsp_valid_nxt  = 1'b1;
            w_misaligned_nxt = w_fault;
          end
        end else begin
          w_req_ready_nxt = 1'b1;
        end
      end
      S_ISSUE: begin
        if (mem_gnt) begin
          if (r_mem_we) begin
            w_state_nxt     = S_DONE;
            w_rsp_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = S_WAIT_R;
          end
        end else begin
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = r_mem_we;
          w_mem_be_nxt    = r_mem_be;
          w_mem_addr_nxt  = r_mem_addr;
          w_mem_wdata_nxt = r_mem_wdata;
        end
      end
      S_WAIT_R: begin
        if (mem_rvalid) begin
          w_state_nxt     = S_DONE;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = w_ext;
        end
      end
      S_DONE: begin
        w_state_nxt     = S_IDLE;
        w_req_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_req_ready_nxt = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_op         <= 6'h0;
      r_lane       <= 2'h0;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= 32'h0;
      r_misaligned <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= 4'h0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_op         <= w_op_nxt;
      r_lane       <= w_lane_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_data   <= w_rsp_data_nxt;
      r_misaligned <= w_misaligned_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_be     <= w_mem_be_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign misaligned = r_misaligned;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_be     = r_mem_be;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule
